// File: rtl/mem_compare_pkg.sv
// Shared types and limits for the mem_compare engine.
package mem_compare_pkg;

    localparam int RD_LAT_MAX  = 4;
    localparam int DRAIN_CNT_W = $clog2(RD_LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_e;

endpackage

// File: rtl/mem_compare_align.sv
// Delays the issued-address valid bit and address by RD_LAT cycles so they line
// up with the returning memory words; RD_LAT=0 is a straight pass-through.
module mem_compare_align #(
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o
);

    generate
        if (RD_LAT == 0) begin : g_bypass
            assign valid_o = valid_i;
            assign addr_o  = addr_i;
        end else begin : g_pipe
            logic [RD_LAT-1:0] valid_q;
            logic [ADDR_W-1:0] addr_q [RD_LAT];

            // NOTE: sequential state uses non-blocking assignments so every stage
            // samples its predecessor's old value on the same edge.
            always_ff @(posedge clk) begin
                if (clr_i) begin
                    valid_q <= '0;
                end else begin
                    valid_q[0] <= valid_i;
                    for (int i = 1; i < RD_LAT; i++) begin
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            // NOTE: the address stages carry no reset; they are only consumed
            // qualified by valid_q, which is cleared.
            always_ff @(posedge clk) begin
                addr_q[0] <= addr_i;
                for (int i = 1; i < RD_LAT; i++) begin
                    addr_q[i] <= addr_q[i-1];
                end
            end

            assign valid_o = valid_q[RD_LAT-1];
            assign addr_o  = addr_q[RD_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/mem_compare.sv
// Sweeps a shared address over two memories and compares the returned words.
// Define MEM_COMPARE_TOL_EN to compare packed complex words within +/-TOL per component.
module mem_compare
    import mem_compare_pkg::*;
#(
    parameter int                  DATA_W = 64,
    parameter int                  ADDR_W = 5,
    parameter int                  DEPTH  = 32,
    parameter int                  RD_LAT = 1,
    parameter logic [DATA_W/2-1:0] TOL    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_comp,
    input  logic [DATA_W-1:0] mema_data,
    input  logic [DATA_W-1:0] memb_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              busy,
    output logic              comp_done,
    output logic              q,
    output logic [ADDR_W:0]   mism_count,
    output logic [ADDR_W-1:0] first_mism_addr
);

    localparam logic [ADDR_W-1:0]      LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [DRAIN_CNT_W-1:0] LAST_DRAIN = DRAIN_CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [DRAIN_CNT_W-1:0]   drain_q, drain_d;
    logic                     start_comp_q;
    logic                     start_pulse;
    logic                     sweep_start;

    logic                     q_q, q_d;
    logic [ADDR_W:0]          mism_q, mism_d;
    logic [ADDR_W-1:0]        first_q, first_d;
    logic                     seen_q, seen_d;

    logic                     pipe_valid;
    logic [ADDR_W-1:0]        pipe_addr;
    logic                     word_match;

    assign start_pulse = start_comp & ~start_comp_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        drain_d     = drain_q;
        sweep_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    state_d     = READ;
                    addr_d      = '0;
                    sweep_start = 1'b1;
                end
            end
            READ: begin
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    drain_d = '0;
                    state_d = (RD_LAT > 0) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                drain_d = drain_q + DRAIN_CNT_W'(1);
                if (drain_q == LAST_DRAIN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mem_compare_align #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_align (
        .clk     (clk),
        .clr_i   (rst),
        .valid_i (state_q == READ),
        .addr_i  (addr_q),
        .valid_o (pipe_valid),
        .addr_o  (pipe_addr)
    );

`ifdef MEM_COMPARE_TOL_EN
    localparam int HALF = DATA_W / 2;

    logic signed [HALF:0] re_diff, im_diff;
    logic        [HALF:0] re_abs, im_abs;

    // Sign-extend by one bit so the difference of two extreme values cannot wrap.
    always_comb begin
        re_diff = $signed({mema_data[DATA_W-1], mema_data[DATA_W-1:HALF]})
                - $signed({memb_data[DATA_W-1], memb_data[DATA_W-1:HALF]});
        im_diff = $signed({mema_data[HALF-1], mema_data[HALF-1:0]})
                - $signed({memb_data[HALF-1], memb_data[HALF-1:0]});
        re_abs  = re_diff[HALF] ? $unsigned(-re_diff) : $unsigned(re_diff);
        im_abs  = im_diff[HALF] ? $unsigned(-im_diff) : $unsigned(im_diff);
        word_match = (re_abs <= {1'b0, TOL}) && (im_abs <= {1'b0, TOL});
    end
`else
    assign word_match = (mema_data == memb_data);
`endif

    always_comb begin
        q_d     = q_q;
        mism_d  = mism_q;
        first_d = first_q;
        seen_d  = seen_q;
        if (sweep_start) begin
            q_d     = 1'b1;
            mism_d  = '0;
            first_d = '0;
            seen_d  = 1'b0;
        end else if (pipe_valid && !word_match) begin
            q_d    = 1'b0;
            mism_d = mism_q + (ADDR_W+1)'(1);
            if (!seen_q) begin
                first_d = pipe_addr;
                seen_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            drain_q      <= '0;
            start_comp_q <= 1'b0;
            q_q          <= 1'b0;
            mism_q       <= '0;
            first_q      <= '0;
            seen_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            drain_q      <= drain_d;
            start_comp_q <= start_comp;
            q_q          <= q_d;
            mism_q       <= mism_d;
            first_q      <= first_d;
            seen_q       <= seen_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign comp_done       = ~busy;
    assign mem_address     = (state_q == READ) ? addr_q : '0;
    assign q               = q_q;
    assign mism_count      = mism_q;
    assign first_mism_addr = first_q;

endmodule

// File: tb/tb_mem_compare.sv
// Directed bench for mem_compare: three instances cover RD_LAT 1/2/0 and DEPTH 32/1.
module tb_mem_compare;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       q;
        logic [5:0] cnt;
        logic [4:0] first;
        logic [4:0] addr;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;

    logic [63:0] a0, b0, a1, b1, a2, b2;
    logic [63:0] a1_s1, b1_s1;
    logic [4:0]  addr0, addr1, addr2;
    logic        busy0, busy1, busy2, done0, done1, done2, q0, q1, q2;
    logic [5:0]  cnt0, cnt1, cnt2;
    logic [4:0]  first0, first1, first2;

    logic [63:0] mem_a [3][32];
    logic [63:0] mem_b [3][32];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_compare #(.DATA_W(64), .ADDR_W(5), .DEPTH(32), .RD_LAT(1), .TOL(32'd0)) dut0 (
        .clk(clk), .rst(rst), .start_comp(start0), .mema_data(a0), .memb_data(b0),
        .mem_address(addr0), .busy(busy0), .comp_done(done0), .q(q0),
        .mism_count(cnt0), .first_mism_addr(first0));

    mem_compare #(.DATA_W(64), .ADDR_W(5), .DEPTH(32), .RD_LAT(2), .TOL(32'd2)) dut1 (
        .clk(clk), .rst(rst), .start_comp(start1), .mema_data(a1), .memb_data(b1),
        .mem_address(addr1), .busy(busy1), .comp_done(done1), .q(q1),
        .mism_count(cnt1), .first_mism_addr(first1));

    mem_compare #(.DATA_W(64), .ADDR_W(5), .DEPTH(1), .RD_LAT(0), .TOL(32'd0)) dut2 (
        .clk(clk), .rst(rst), .start_comp(start2), .mema_data(a2), .memb_data(b2),
        .mem_address(addr2), .busy(busy2), .comp_done(done2), .q(q2),
        .mism_count(cnt2), .first_mism_addr(first2));

    // Memory models with the read latency each instance expects.
    always @(posedge clk) begin
        a0    <= mem_a[0][addr0];
        b0    <= mem_b[0][addr0];
        a1_s1 <= mem_a[1][addr1];
        b1_s1 <= mem_b[1][addr1];
        a1    <= a1_s1;
        b1    <= b1_s1;
    end

    always_comb begin
        a2 = mem_a[2][addr2];
        b2 = mem_b[2][addr2];
    end

    function automatic obs_t snap(int id);
        obs_t o;
        case (id)
            0:       begin o.busy = busy0; o.done = done0; o.q = q0; o.cnt = cnt0; o.first = first0; o.addr = addr0; end
            1:       begin o.busy = busy1; o.done = done1; o.q = q1; o.cnt = cnt1; o.first = first1; o.addr = addr1; end
            default: begin o.busy = busy2; o.done = done2; o.q = q2; o.cnt = cnt2; o.first = first2; o.addr = addr2; end
        endcase
        return o;
    endfunction

    task automatic set_start(int id, logic v);
        case (id)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic fill(int id);
        for (int k = 0; k < 32; k++) begin
            mem_a[id][k] = {32'(k * 3 + 1), 32'(k * 5 + 2)};
            mem_b[id][k] = mem_a[id][k];
        end
    endtask

    // Raise start at a falling edge and count cycles until comp_done, bounded.
    task automatic run_sweep(int id, output int cyc);
        @(negedge clk);
        set_start(id, 1'b1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!snap(id).done && cyc < 200);
        set_start(id, 1'b0);
    endtask

    task automatic test_reset();
        obs_t o;
        repeat (3) @(negedge clk);
        o = snap(0);
        vectors++; if (o.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", o.busy); end
        vectors++; if (o.done !== 1'b1) begin miscompares++; $display("FAIL reset_done: got %0b want 1", o.done); end
        vectors++; if (o.q !== 1'b0) begin miscompares++; $display("FAIL reset_q: got %0b want 0", o.q); end
        vectors++; if (o.cnt !== 6'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", o.cnt); end
        vectors++; if (o.first !== 5'd0) begin miscompares++; $display("FAIL reset_first: got %0d want 0", o.first); end
        vectors++; if (o.addr !== 5'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", o.addr); end
        rst = 1'b0;
    endtask

    task automatic test_identical();
        obs_t o;
        int   c;
        fill(0);
        @(negedge clk);
        start0 = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            o = snap(0);
            if (c == 1) begin
                vectors++; if (o.addr !== 5'd0 || o.busy !== 1'b1) begin miscompares++; $display("FAIL ident_c1: addr %0d busy %0b want 0/1", o.addr, o.busy); end
            end
            if (c == 2) begin
                vectors++; if (o.addr !== 5'd1) begin miscompares++; $display("FAIL ident_c2_addr: got %0d want 1", o.addr); end
            end
            if (c == 32) begin
                vectors++; if (o.addr !== 5'd31) begin miscompares++; $display("FAIL ident_c32_addr: got %0d want 31", o.addr); end
            end
            if (c == 33) begin
                vectors++; if (o.addr !== 5'd0 || o.done !== 1'b0) begin miscompares++; $display("FAIL ident_drain: addr %0d done %0b want 0/0", o.addr, o.done); end
            end
        end while (!o.done && c < 200);
        start0 = 1'b0;
        vectors++; if (c != 34) begin miscompares++; $display("FAIL ident_latency: got %0d want 34", c); end
        vectors++; if (o.q !== 1'b1) begin miscompares++; $display("FAIL ident_q: got %0b want 1", o.q); end
        vectors++; if (o.cnt !== 6'd0) begin miscompares++; $display("FAIL ident_cnt: got %0d want 0", o.cnt); end
        vectors++; if (o.first !== 5'd0) begin miscompares++; $display("FAIL ident_first: got %0d want 0", o.first); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int   c;
        fill(0);
        mem_b[0][7] = mem_b[0][7] ^ 64'h1;
        @(negedge clk);
        start0 = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (c == 5)  start0 = 1'b0;
            if (c == 10) start0 = 1'b1;
            o = snap(0);
        end while (!o.done && c < 200);
        vectors++; if (c != 34) begin miscompares++; $display("FAIL b2b_latency: got %0d want 34", c); end
        vectors++; if (o.cnt !== 6'd1 || o.first !== 5'd7 || o.q !== 1'b0) begin
            miscompares++; $display("FAIL b2b_result: cnt %0d first %0d q %0b want 1/7/0", o.cnt, o.first, o.q);
        end
        // start still high: must not retrigger
        repeat (3) @(negedge clk);
        o = snap(0);
        vectors++; if (o.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_no_retrigger: busy %0b want 0", o.busy); end
        fill(0);
        start0 = 1'b0;
        run_sweep(0, c);
        o = snap(0);
        vectors++; if (c != 34) begin miscompares++; $display("FAIL b2b_fresh_latency: got %0d want 34", c); end
        vectors++; if (o.q !== 1'b1 || o.cnt !== 6'd0 || o.first !== 5'd0) begin
            miscompares++; $display("FAIL b2b_fresh: q %0b cnt %0d first %0d want 1/0/0", o.q, o.cnt, o.first);
        end
    endtask

    task automatic test_reset_abort();
        obs_t o;
        fill(0);
        mem_b[0][2] = mem_b[0][2] ^ 64'h8000_0000_0000_0000;
        @(negedge clk);
        start0 = 1'b1;
        repeat (15) @(negedge clk);
        o = snap(0);
        vectors++; if (o.cnt !== 6'd1 || o.busy !== 1'b1) begin miscompares++; $display("FAIL abort_pre: cnt %0d busy %0b want 1/1", o.cnt, o.busy); end
        rst = 1'b1;
        @(negedge clk);
        o = snap(0);
        vectors++; if (o.busy !== 1'b0 || o.done !== 1'b1) begin miscompares++; $display("FAIL abort_state: busy %0b done %0b want 0/1", o.busy, o.done); end
        vectors++; if (o.q !== 1'b0 || o.cnt !== 6'd0 || o.first !== 5'd0) begin
            miscompares++; $display("FAIL abort_results: q %0b cnt %0d first %0d want 0/0/0", o.q, o.cnt, o.first);
        end
        start0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        o = snap(0);
        vectors++; if (o.busy !== 1'b0) begin miscompares++; $display("FAIL abort_rst_priority: busy %0b want 0", o.busy); end
        start0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        o = snap(0);
        vectors++; if (o.busy !== 1'b0) begin miscompares++; $display("FAIL abort_release: busy %0b want 0", o.busy); end
    endtask

    task automatic test_mismatch();
        obs_t o;
        int   c;
        fill(1);
        mem_b[1][5]  = mem_b[1][5]  ^ 64'h0000_0100_0000_0000;
        mem_b[1][17] = mem_b[1][17] ^ 64'h0000_0100_0000_0000;
        mem_b[1][31] = mem_b[1][31] ^ 64'h0000_0100_0000_0000;
        run_sweep(1, c);
        o = snap(1);
        vectors++; if (c != 35) begin miscompares++; $display("FAIL mism_latency: got %0d want 35", c); end
        vectors++; if (o.q !== 1'b0) begin miscompares++; $display("FAIL mism_q: got %0b want 0", o.q); end
        vectors++; if (o.cnt !== 6'd3) begin miscompares++; $display("FAIL mism_cnt: got %0d want 3", o.cnt); end
        vectors++; if (o.first !== 5'd5) begin miscompares++; $display("FAIL mism_first: got %0d want 5", o.first); end
    endtask

    task automatic test_tolerance();
        obs_t o;
        int   c;
        int   exp_cnt, exp_first;
`ifdef MEM_COMPARE_TOL_EN
        exp_cnt   = 1;
        exp_first = 9;
`else
        exp_cnt   = 2;
        exp_first = 3;
`endif
        fill(1);
        mem_b[1][3][63:32] = mem_a[1][3][63:32] + 32'd2;
        mem_b[1][9][31:0]  = mem_a[1][9][31:0] + 32'd3;
        run_sweep(1, c);
        o = snap(1);
        vectors++; if (o.cnt !== 6'(exp_cnt)) begin miscompares++; $display("FAIL tol_cnt: got %0d want %0d", o.cnt, exp_cnt); end
        vectors++; if (o.first !== 5'(exp_first)) begin miscompares++; $display("FAIL tol_first: got %0d want %0d", o.first, exp_first); end
        fill(1);
        mem_a[1][12][63:32] = 32'h7FFF_FFFF;
        mem_b[1][12][63:32] = 32'h8000_0000;
        run_sweep(1, c);
        o = snap(1);
        vectors++; if (o.cnt !== 6'd1 || o.first !== 5'd12 || o.q !== 1'b0) begin
            miscompares++; $display("FAIL tol_extreme: cnt %0d first %0d q %0b want 1/12/0", o.cnt, o.first, o.q);
        end
    endtask

    task automatic test_single();
        obs_t o;
        int   c;
        fill(2);
        mem_b[2][0] = mem_b[2][0] ^ 64'h10;
        @(negedge clk);
        start2 = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            o = snap(2);
            vectors++; if (o.addr !== 5'd0) begin miscompares++; $display("FAIL single_addr c%0d: got %0d want 0", c, o.addr); end
        end while (!o.done && c < 50);
        start2 = 1'b0;
        vectors++; if (c != 2) begin miscompares++; $display("FAIL single_latency: got %0d want 2", c); end
        vectors++; if (o.q !== 1'b0 || o.cnt !== 6'd1 || o.first !== 5'd0) begin
            miscompares++; $display("FAIL single_mism: q %0b cnt %0d first %0d want 0/1/0", o.q, o.cnt, o.first);
        end
        fill(2);
        run_sweep(2, c);
        o = snap(2);
        vectors++; if (o.q !== 1'b1 || o.cnt !== 6'd0) begin
            miscompares++; $display("FAIL single_match: q %0b cnt %0d want 1/0", o.q, o.cnt);
        end
    endtask

    initial begin
        fill(0);
        fill(1);
        fill(2);
        test_reset();
        test_identical();
        test_back_to_back();
        test_reset_abort();
        test_mismatch();
        test_tolerance();
        test_single();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_compare.md
# mem_compare

Parametrised memory-comparison engine for the FFT verification path. On a start request it sweeps a shared address over two result memories and compares their words, allowing for a configurable memory read latency. It reports pass/fail, the mismatch count and the first failing address. With the tolerance option compiled in, each word is treated as a packed complex sample (real upper half, imaginary lower half) and compared within a per-component tolerance, so that fixed-point FFT outputs can be checked against a golden memory.

## Interface
- DATA_W, 64: memory word width; must be even.
- ADDR_W, 5: address width.
- DEPTH, 32: number of words compared; 1 ≤ DEPTH ≤ 2^ADDR_W.
- RD_LAT, 1: memory read latency in cycles (address to data); 0 ≤ RD_LAT ≤ 4.
- TOL, 0: per-component absolute tolerance (unsigned, DATA_W/2 bits). Used only when MEM_COMPARE_TOL_EN is defined.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start_comp  in  1  level; its rising edge starts a comparison.
- mema_data  in  DATA_W  word from memory A for the address issued RD_LAT cycles earlier.
- memb_data  in  DATA_W  word from memory B, same alignment.
- mem_address  out  ADDR_W  shared read address.
- busy  out  1  comparison in progress.
- comp_done  out  1  high whenever idle; results are stable while high.
- q  out  1  1 = all compared words matched.
- mism_count  out  ADDR_W+1  number of mismatching words.
- first_mism_addr  out  ADDR_W  address of the first mismatch; 0 if none.

## Operation
- Start detection: start_comp is registered. start_pulse = start_comp & ~start_comp_d.
- FSM states:
  - IDLE: start_pulse → READ.
  - READ: issues addresses 0..DEPTH-1, one per cycle. After DEPTH-1 is issued, goes to DRAIN if RD_LAT > 0, otherwise to IDLE.
  - DRAIN: holds for RD_LAT cycles, then → IDLE.
- On start_pulse:
  - q ← 1
  - mism_count ← 0
  - first_mism_addr ← 0
  - internal first-seen flag cleared
- Alignment pipeline: a valid bit and the issued address travel RD_LAT stages. When the delayed valid is high, the compare result is registered:
  - On mismatch: q ← 0 and mism_count increments.
  - On the first mismatch only: first_mism_addr ← delayed address.
- mism_count never wraps, because DEPTH ≤ 2^ADDR_W < 2^(ADDR_W+1).
- mem_address holds 0 outside READ.
- start_pulse while busy is ignored and does not restart the sweep. A start_comp level still high at the end of a sweep does not retrigger; only a new rising edge does.
- rst mid-sweep aborts immediately: FSM → IDLE, pipeline valids cleared, all outputs to their reset values. rst has priority over a simultaneous start_pulse.
- Reset values:
  - busy=0, comp_done=1, mem_address=0
  - q=0, mism_count=0, first_mism_addr=0
  - start_comp_d=0
- Because start_comp_d resets to 0, a start_comp already high when rst deasserts starts a sweep on the first cycle after reset.

## Timing
- Cycle 0: the edge at which start_pulse is sampled high.
- Cycles 1..DEPTH: busy=1, comp_done=0, mem_address=k during cycle 1+k.
- Data for address k is sampled on the rising edge ending cycle 1+k+RD_LAT.
- The last compare result is registered at the end of cycle DEPTH+RD_LAT.
- comp_done rises and busy falls at the start of cycle DEPTH+RD_LAT+1. q, mism_count and first_mism_addr are final at that point.
- Total latency from start edge to comp_done is DEPTH+RD_LAT+1 cycles.
- A new start is accepted from the first cycle comp_done=1.

## Configuration
- MEM_COMPARE_TOL_EN defined: each word splits into re=[DATA_W-1:DATA_W/2] and im=[DATA_W/2-1:0], both signed two's complement.
  - Difference per component is computed at DATA_W/2+1 bits (no overflow), then its absolute value is taken.
  - Match iff |re_a-re_b| ≤ TOL and |im_a-im_b| ≤ TOL.
- Undefined: match iff mema_data == memb_data. TOL is ignored and no subtractors are synthesised.

## Structure
- Package mem_compare_pkg holds:
  - the FSM state enum (IDLE, READ, DRAIN)
  - the RD_LAT upper bound constant (4)
- Sub-module mem_compare_align: RD_LAT-deep valid+address delay line, with RD_LAT=0 as a pass-through. Its synchronous clear is driven by rst.
- The comparator stays inline in mem_compare.

## Test plan
- Identical memories, DEPTH=32, RD_LAT=1, exact mode:
  - comp_done rises 34 cycles after the start edge
  - q=1, mism_count=0, first_mism_addr=0
- Memory B differs at addresses 5, 17 and 31, RD_LAT=2:
  - q=0, mism_count=3, first_mism_addr=5
  - done at cycle 35
- MEM_COMPARE_TOL_EN, TOL=2:
  - re differs by 2 at address 3 → still matches
  - im differs by 3 at address 9 → mism_count=1, first_mism_addr=9
  - re_a=0x7FFFFFFF, re_b=0x80000000 at address 12 → counted as a mismatch (no wrap)
- Second start_comp rising edge at cycle 10 of a sweep → ignored, done timing unchanged; a start after done → fresh results.
- rst asserted at cycle 15 of a sweep:
  - next cycle busy=0, comp_done=1, q=0, mism_count=0
  - rst and start_pulse together → stays IDLE
- DEPTH=1, RD_LAT=0:
  - single compare
  - done 2 cycles after the start edge
  - mem_address=0 throughout
